opll_write_sched: RTL and testbench

Write scheduler between the CPU I/O decode and the three OPLL instances (cartridge A, cartridge B, internal). It queues CPU register writes in a shared FIFO and issues them to the OPLL bus one at a time. Each write becomes a chip-select/write strobe that spans a fixed number of master-clock enables. After each strobe, the target chip is held busy for the YM2413 post-write recovery time: 12 master cycles after an address write, 84 after a data write. CPU software therefore never violates OPLL write timing, whatever its own write rate.

---
 rtl/opll_write_sched_if.sv | 27 ++
 rtl/opll_write_sched.sv | 140 ++++++++++++++
 tb/tb_opll_write_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/opll_write_sched_if.sv
// CPU request / OPLL bus bundle for the write scheduler.
// master = CPU-side driver, slave = the scheduler itself.
interface opll_write_sched_if #(
  parameter int DEPTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_chip;
  logic                   req_addr;
  logic [7:0]             req_data;
  logic [2:0]             opll_cs;
  logic [2:0]             opll_wr;
  logic                   opll_addr;
  logic [7:0]             opll_din;
  logic [2:0]             busy;
  logic [$clog2(DEPTH):0] level;
  logic                   err;

  modport master (
    output req_valid, req_chip, req_addr, req_data,
    input  req_ready, opll_cs, opll_wr, opll_addr, opll_din, busy, level, err
  );
  modport slave (
    input  req_valid, req_chip, req_addr, req_data,
    output req_ready, opll_cs, opll_wr, opll_addr, opll_din, busy, level, err
  );
endinterface

// File: rtl/opll_write_sched.sv
// Queues CPU OPLL writes and issues them one at a time, honouring the
// YM2413 per-chip post-write recovery time counted in master-clock enables.
module opll_write_sched #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84,
  parameter int STROBE_CEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  opll_write_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STROBE_CEN + 1);

  typedef struct packed {
    logic [1:0] chip;
    logic       addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic {IDLE, STROBE} state_t;

  req_t            mem [DEPTH];
  req_t            head;
  logic [PW-1:0]   wptr, rptr;
  logic [LW-1:0]   level;
  logic            push, pop, issue, drop, strobe_end;
  logic [2:0]      busy;
  logic [3:0]      busy_ext;
  logic [SW-1:0]   scnt;
  logic [2:0]      cs;
  logic            a0;
  logic [7:0]      din;
  logic            err;
  state_t          state, state_nx;

  assign bus.req_ready = (level != LW'(DEPTH));
  assign push          = bus.req_valid & bus.req_ready;
  assign head          = mem[rptr];
  assign pop           = issue | drop;
  // chip=3 never reaches the busy lookup, the extra bit just keeps the index in range
  assign busy_ext      = {1'b0, busy};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{chip: bus.req_chip, addr: bus.req_addr, data: bus.req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    drop       = 1'b0;
    strobe_end = 1'b0;
    case (state)
      IDLE: begin
        // head-of-line blocking keeps the global write order intact
        if (level != '0) begin
          if (head.chip == 2'd3) begin
            drop = 1'b1;
          end else if (!busy_ext[head.chip]) begin
            issue    = 1'b1;
            state_nx = STROBE;
          end
        end
      end
      STROBE: begin
        if (cen && scnt == SW'(1)) begin
          strobe_end = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      cs   <= '0;
      a0   <= 1'b0;
      din  <= '0;
      err  <= 1'b0;
    end else begin
      if (issue) begin
        scnt <= SW'(STROBE_CEN);
        cs   <= 3'(3'b001 << head.chip);
        a0   <= head.addr;
        din  <= head.data;
      end else if (strobe_end) begin
        scnt <= '0;
        cs   <= '0;
      end else if (state == STROBE && cen) begin
        scnt <= scnt - SW'(1);
      end
      if (drop) err <= 1'b1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_rec
    logic [6:0] c;
    // a load at strobe end wins over the decrement of the same cen
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                        c <= '0;
      else if (strobe_end && cs[k])   c <= a0 ? 7'(DATA_WAIT) : 7'(ADDR_WAIT);
      else if (cen && c != '0)        c <= c - 7'd1;
    end
    assign busy[k] = (c != '0);
  end

  assign bus.opll_cs   = cs;
  assign bus.opll_wr   = cs;
  assign bus.opll_addr = a0;
  assign bus.opll_din  = din;
  assign bus.busy      = busy;
  assign bus.level     = level;
  assign bus.err       = err;
endmodule

// File: tb/tb_opll_write_sched.sv
// Directed bench for opll_write_sched: scoreboard of expected strobes plus
// timing checks on strobe length, recovery windows and issue latency.
module tb_opll_write_sched;
  localparam int DEPTH = 8, AW = 12, DW = 84, SC = 2;

  typedef struct {logic [1:0] chip; logic addr; logic [7:0] data;} exp_t;
  typedef struct {int cyc; int cenc; logic [2:0] cs;} ev_t;

  logic clk = 1'b0, rst = 1'b1, cen = 1'b0;
  bit   cen_en = 1'b1;
  int   cyc = 0, cen_cnt = 0, passed = 0, total = 0;
  exp_t sb[$];
  ev_t  starts[$], ends[$];
  int   end_cen[3], wait_exp[3], busy_fall_cyc[3];
  logic [2:0] prev_cs, prev_busy;

  opll_write_sched_if #(.DEPTH(DEPTH)) bus ();
  opll_write_sched #(.DEPTH(DEPTH), .ADDR_WAIT(AW), .DATA_WAIT(DW), .STROBE_CEN(SC)) dut (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cen changes on negedge so its value is stable across each posedge
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      ph  = (ph + 1) % 4;
      cen = cen_en && (ph == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // monitor: strobe contents vs scoreboard, strobe length, recovery windows
  initial begin
    exp_t e;
    prev_cs = '0; prev_busy = '0;
    forever begin
      @(posedge clk); #1;
      if (cen) cen_cnt++;
      if (rst) begin
        prev_cs = '0; prev_busy = '0;
      end else begin
        if (bus.opll_cs != 0 && prev_cs == 0) begin
          starts.push_back('{cyc, cen_cnt, bus.opll_cs});
          if (sb.size() > 0) e = sb.pop_front();
          else e = '{2'd3, 1'b0, 8'h00};
          chk("strobe_cs", bus.opll_cs, (e.chip == 2'd3) ? 3'b000 : 3'(3'b001 << e.chip));
          chk("strobe_wr", bus.opll_wr, bus.opll_cs);
          chk("strobe_addr", bus.opll_addr, e.addr);
          chk("strobe_din", bus.opll_din, e.data);
        end
        if (bus.opll_cs == 0 && prev_cs != 0) begin
          ends.push_back('{cyc, cen_cnt, prev_cs});
          chk("strobe_cens", cen_cnt - starts[$].cenc, SC);
          for (int k = 0; k < 3; k++)
            if (prev_cs[k]) begin
              end_cen[k]  = cen_cnt;
              wait_exp[k] = bus.opll_addr ? DW : AW;
            end
        end
        for (int k = 0; k < 3; k++)
          if (!bus.busy[k] && prev_busy[k]) begin
            busy_fall_cyc[k] = cyc;
            chk($sformatf("busy_cens_%0d", k), cen_cnt - end_cen[k], wait_exp[k]);
          end
        prev_cs   = bus.opll_cs;
        prev_busy = bus.busy;
      end
    end
  end

  task automatic push(input logic [1:0] c, input logic a, input logic [7:0] d,
                      output bit acc, output int acc_cyc);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_chip = c; bus.req_addr = a; bus.req_data = d;
    acc = bus.req_ready;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (acc && c != 2'd3) sb.push_back('{c, a, d});
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_q(input string tag, input bit use_ends, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #2;
      ok = use_ends ? (ends.size() >= n) : (starts.size() >= n);
    end
    chk({"wait_", tag}, ok, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #2;
      ok = (bus.level == 0) && (bus.opll_cs == 0) && (bus.busy == 0) && (sb.size() == 0);
    end
    chk({"idle_", tag}, ok, 1'b1);
  endtask

  initial begin
    bit acc;
    int ac, ac2, n;
    bus.req_valid = 1'b1; bus.req_chip = 2'd2; bus.req_addr = 1'b0; bus.req_data = 8'hAA;

    // reset state; the request held during reset must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", bus.opll_cs, 3'b000);
    chk("rst_wr", bus.opll_wr, 3'b000);
    chk("rst_addr", bus.opll_addr, 1'b0);
    chk("rst_din", bus.opll_din, 8'h00);
    chk("rst_busy", bus.busy, 3'b000);
    chk("rst_level", bus.level, 4'd0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // single write
    n = starts.size();
    push(2'd2, 1'b0, 8'h10, acc, ac);
    chk("single_acc", acc, 1'b1);
    wait_q("single", 1'b0, n + 1);
    chk("single_latency", starts[n].cyc, ac + 1);
    chk("single_cs", starts[n].cs, 3'b100);
    wait_idle("single");
    chk("din_hold", bus.opll_din, 8'h10);

    // address+data pair to chip A
    n = starts.size();
    push(2'd0, 1'b0, 8'h30, acc, ac);
    push(2'd0, 1'b1, 8'h5A, acc, ac);
    wait_q("pair", 1'b0, n + 2);
    chk("pair_gap_cyc", starts[n+1].cyc, busy_fall_cyc[0] + 1);
    chk("pair_gap_cen", starts[n+1].cenc - ends[ends.size()-1].cenc, AW);
    wait_idle("pair");

    // interleaved A-data, B-data, A-data
    n = starts.size();
    push(2'd0, 1'b1, 8'h11, acc, ac);
    push(2'd1, 1'b1, 8'h22, acc, ac);
    push(2'd0, 1'b1, 8'h33, acc, ac);
    wait_q("inter", 1'b0, n + 3);
    chk("inter_b_follows", starts[n+1].cyc, ends[ends.size()-2].cyc + 1);
    chk("inter_third_waits", starts[n+2].cyc, busy_fall_cyc[0] + 1);
    wait_idle("inter");

    // FIFO full with cen held low: first entry is issued and its strobe
    // stalls, the next eight fill the FIFO, the one after is refused
    cen_en = 1'b0;
    repeat (2) @(negedge clk);
    n = starts.size();
    for (int i = 0; i < 10; i++) begin
      push(2'(i % 3), 1'b0, 8'(8'h80 + i), acc, ac);
      chk($sformatf("full_acc_%0d", i), acc, (i < 9) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("full_level", bus.level, 4'd8);
    chk("full_ready", bus.req_ready, 1'b0);
    cen_en = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(posedge clk); #2;
      acc = bus.req_ready;
    end
    chk("full_ready_back", acc, 1'b1);
    chk("full_level_after_pop", bus.level, 4'd7);
    chk("full_issued_at_ready", starts.size(), n + 2);
    wait_idle("full");
    chk("full_all_issued", starts.size(), n + 9);

    // invalid chip entry is dropped, valid one follows
    chk("err_before", bus.err, 1'b0);
    n = starts.size();
    push(2'd3, 1'b0, 8'hEE, acc, ac);
    push(2'd2, 1'b1, 8'h77, acc, ac2);
    wait_q("inv", 1'b0, n + 1);
    chk("inv_latency", starts[n].cyc, ac + 2);
    chk("inv_err", bus.err, 1'b1);
    wait_idle("inv");
    chk("inv_one_strobe", starts.size(), n + 1);
    chk("inv_err_sticky", bus.err, 1'b1);

    // reset mid-strobe with chip A recovering and three entries queued
    n = ends.size();
    push(2'd0, 1'b1, 8'h40, acc, ac);
    wait_q("rstm_end", 1'b1, n + 1);
    cen_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstm_busy0", bus.busy[0], 1'b1);
    push(2'd1, 1'b0, 8'h41, acc, ac);
    push(2'd1, 1'b1, 8'h42, acc, ac);
    push(2'd1, 1'b0, 8'h43, acc, ac);
    push(2'd1, 1'b1, 8'h44, acc, ac);
    @(negedge clk);
    chk("rstm_cs_pre", bus.opll_cs, 3'b010);
    chk("rstm_level_pre", bus.level, 4'd3);
    rst = 1'b1;
    #1;
    chk("rstm_cs", bus.opll_cs, 3'b000);
    chk("rstm_wr", bus.opll_wr, 3'b000);
    chk("rstm_level", bus.level, 4'd0);
    chk("rstm_busy", bus.busy, 3'b000);
    chk("rstm_err", bus.err, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cen_en = 1'b1;
    n = starts.size();
    push(2'd2, 1'b0, 8'h99, acc, ac);
    chk("post_rst_acc", acc, 1'b1);
    wait_q("post_rst", 1'b0, n + 1);
    chk("post_rst_latency", starts[n].cyc, ac + 1);
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
